// File: rtl/ram8_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_arbiter_pkg
//  Description : Shared widths and FSM state encoding for the two-port
//                arbiter that fronts an 8x16 single-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram8_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // Arbiter sequencing: accept one request, spend one cycle on the RAM,
    // then hold the response until its owner takes it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage : ram8_arbiter_pkg
`default_nettype wire

// File: rtl/ram8_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input grant selector. A lone request is granted
//                directly; a tie goes to requester 0 under fixed priority,
//                otherwise to whichever requester was not granted last.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant; all-zero when nothing is requesting.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (FIXED_PRIO || last_grant) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_arbiter
//  Description : Arbitrates two valid/ready requesters onto one 8x16 RAM.
//                One access at a time: handshake, one RAM cycle, then a
//                response held for the owning requester until consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram8_arbiter
    import ram8_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              CLK,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              rsp0_ready,

    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              rsp1_ready,

    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_last_grant;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rsp_data;

    logic [1:0]          w_grant;
    logic                w_handshake;
    logic                w_owner_rsp_ready;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // The grantee always sees ready in IDLE, so any grant is a handshake.
    assign w_handshake       = (r_state == IDLE) && (w_grant != 2'b00);
    assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    // State register plus capture of the accepted request and RAM result.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_owner      <= w_grant[1];
                r_last_grant <= w_grant[1];
                r_we         <= w_grant[1] ? req1_we    : req0_we;
                r_addr       <= w_grant[1] ? req1_addr  : req0_addr;
                r_wdata      <= w_grant[1] ? req1_wdata : req0_wdata;
            end
            if (r_state == ACCESS) begin
                r_rsp_data <= r_we ? '0 : ram_out;
            end
        end
    end

    // Next-state selection and all port outputs decoded from the state.
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        rsp0_rdata  = '0;
        rsp1_rdata  = '0;
        ram_in      = '0;
        ram_address = '0;
        ram_load    = 1'b0;

        unique case (r_state)
            IDLE: begin
                req0_ready = w_grant[0];
                req1_ready = w_grant[1];
                if (w_handshake) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_address = r_addr;
                ram_in      = r_wdata;
                // Reset must be able to cancel a write in this very cycle.
                ram_load    = r_we & ~reset;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (r_owner) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = r_rsp_data;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = r_rsp_data;
                end
                if (w_owner_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : ram8_arbiter
`default_nettype wire

// File: tb/tb_ram8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram8_arbiter
//  Description : Directed self-checking bench. Instance a runs round-robin,
//                instance b fixed priority; each has its own 8x16 RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram8_arbiter;

    logic CLK = 1'b0;
    logic reset = 1'b1;

    always #5 CLK = ~CLK;

    // ---------------- instance a (round-robin) ----------------
    logic        a_req0_valid = 0, a_req0_we = 0, a_req0_ready;
    logic [2:0]  a_req0_addr = 0;
    logic [15:0] a_req0_wdata = 0;
    logic        a_req1_valid = 0, a_req1_we = 0, a_req1_ready;
    logic [2:0]  a_req1_addr = 0;
    logic [15:0] a_req1_wdata = 0;
    logic        a_rsp0_valid, a_rsp1_valid;
    logic        a_rsp0_ready = 0, a_rsp1_ready = 0;
    logic [15:0] a_rsp0_rdata, a_rsp1_rdata;
    logic [15:0] a_ram_in, a_ram_out;
    logic [2:0]  a_ram_address;
    logic        a_ram_load;
    logic [15:0] mem_a [8] = '{default: 16'h0000};

    // ---------------- instance b (fixed priority) ----------------
    logic        b_req0_valid = 0, b_req1_valid = 0, b_req0_ready, b_req1_ready;
    logic        b_rsp0_valid, b_rsp1_valid;
    logic        b_rsp0_ready = 0, b_rsp1_ready = 0;
    logic [15:0] b_rsp0_rdata, b_rsp1_rdata;
    logic [15:0] b_ram_in, b_ram_out;
    logic [2:0]  b_ram_address;
    logic        b_ram_load;
    logic [15:0] mem_b [8] = '{default: 16'h0000};

    ram8_arbiter #(.FIXED_PRIO(1'b0)) dut_a (
        .CLK(CLK), .reset(reset),
        .req0_valid(a_req0_valid), .req0_we(a_req0_we), .req0_addr(a_req0_addr),
        .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_we(a_req1_we), .req1_addr(a_req1_addr),
        .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
        .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata), .rsp0_ready(a_rsp0_ready),
        .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata), .rsp1_ready(a_rsp1_ready),
        .ram_in(a_ram_in), .ram_address(a_ram_address), .ram_load(a_ram_load),
        .ram_out(a_ram_out)
    );

    ram8_arbiter #(.FIXED_PRIO(1'b1)) dut_b (
        .CLK(CLK), .reset(reset),
        .req0_valid(b_req0_valid), .req0_we(1'b0), .req0_addr(3'd0),
        .req0_wdata(16'h0000), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_we(1'b0), .req1_addr(3'd1),
        .req1_wdata(16'h0000), .req1_ready(b_req1_ready),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata), .rsp0_ready(b_rsp0_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata), .rsp1_ready(b_rsp1_ready),
        .ram_in(b_ram_in), .ram_address(b_ram_address), .ram_load(b_ram_load),
        .ram_out(b_ram_out)
    );

    // RAM models: combinational read, write at the edge ending a load cycle.
    assign a_ram_out = mem_a[a_ram_address];
    assign b_ram_out = mem_b[b_ram_address];
    always @(posedge CLK) if (a_ram_load) mem_a[a_ram_address] <= a_ram_in;
    always @(posedge CLK) if (b_ram_load) mem_b[b_ram_address] <= b_ram_in;

    // Watch for requester 1 of the fixed-priority instance ever being offered.
    logic tie_b = 1'b0;
    logic b_r1_seen = 1'b0;
    always @(negedge CLK) if (tie_b && b_req1_ready) b_r1_seen <= 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [55:0] a_outs();
        return {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_ram_load,
                a_ram_address, a_rsp0_rdata, a_rsp1_rdata, a_ram_in};
    endfunction

    initial begin
        // Reset state
        cyc();
        #1 check("reset_outs_a", a_outs(), 56'd0);
        check("reset_outs_b", {b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_ram_load}, 5'd0);
        reset = 1'b0;
        cyc();
        #1 check("idle_no_req", a_outs(), 56'd0);

        // Write 16'hBEEF to address 3 from requester 0
        a_req0_valid = 1; a_req0_we = 1; a_req0_addr = 3'd3; a_req0_wdata = 16'hBEEF;
        #1 check("wr_ready", {a_req0_ready, a_req1_ready}, 2'b10);
        cyc();
        a_req0_valid = 0;
        #1 check("wr_access", {a_ram_load, a_ram_address, a_ram_in, a_req0_ready}, {1'b1, 3'd3, 16'hBEEF, 1'b0});
        cyc();
        #1 check("wr_resp", {a_rsp0_valid, a_rsp0_rdata, a_rsp1_valid, a_ram_load}, {1'b1, 16'h0000, 1'b0, 1'b0});
        a_rsp0_ready = 1;
        cyc();
        #1 check("wr_done", {a_rsp0_valid, a_req0_ready}, 2'b00);

        // Requester 1 reads address 3 back
        a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 3'd3;
        a_rsp1_ready = 1;
        #1 check("rd_ready", {a_req0_ready, a_req1_ready}, 2'b01);
        cyc();
        a_req1_valid = 0;
        #1 check("rd_access", {a_ram_load, a_ram_address}, {1'b0, 3'd3});
        cyc();
        #1 check("rd_resp", {a_rsp1_valid, a_rsp1_rdata, a_rsp0_valid, a_rsp0_rdata}, {1'b1, 16'hBEEF, 1'b0, 16'h0000});
        cyc();

        // Ties: round-robin alternates, fixed priority keeps requester 0
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 3'd3;
        a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 3'd3;
        b_req0_valid = 1; b_req1_valid = 1; b_rsp0_ready = 1; b_rsp1_ready = 1;
        tie_b = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("rr_grant%0d", i), {a_req1_ready, a_req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i < 2) check($sformatf("fp_grant%0d", i), {b_req1_ready, b_req0_ready}, 2'b01);
            repeat (3) @(posedge CLK);
            @(negedge CLK);
        end
        a_req0_valid = 0; a_req1_valid = 0;
        b_req0_valid = 0; b_req1_valid = 0;
        tie_b = 0;
        check("fp_req1_never_ready", b_r1_seen, 1'b0);

        // Backpressure on requester 0's response
        a_rsp0_ready = 0;
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 3'd3;
        #1 check("bp_ready", a_req0_ready, 1'b1);
        cyc();
        a_req0_valid = 0;
        cyc();
        a_req1_valid = 1; a_req1_we = 1; a_req1_addr = 3'd5; a_req1_wdata = 16'h5A5A;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("bp_hold%0d", i),
                     {a_rsp0_valid, a_rsp0_rdata, a_req0_ready, a_req1_ready, a_rsp1_valid},
                     {1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0});
            cyc();
        end
        a_rsp0_ready = 1;
        cyc();
        #1 check("bp_released", {a_rsp0_valid, a_req0_ready, a_req1_ready}, 3'b001);
        cyc();
        a_req1_valid = 0;
        #1 check("wr5_access", {a_ram_load, a_ram_address, a_ram_in}, {1'b1, 3'd5, 16'h5A5A});
        cyc();
        #1 check("wr5_resp", {a_rsp1_valid, a_rsp1_rdata}, {1'b1, 16'h0000});
        cyc();

        // Reset arriving during the ACCESS cycle of a write
        a_req0_valid = 1; a_req0_we = 1; a_req0_addr = 3'd5; a_req0_wdata = 16'h1234;
        #1 check("rst_wr_ready", a_req0_ready, 1'b1);
        cyc();
        a_req0_valid = 0;
        reset = 1;
        #1 check("rst_load_forced", a_ram_load, 1'b0);
        cyc();
        reset = 0;
        #1 check("rst_outs_zero", a_outs(), 56'd0);
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 3'd5;
        cyc();
        a_req0_valid = 0;
        cyc();
        #1 check("rst_addr5_kept", {a_rsp0_valid, a_rsp0_rdata}, {1'b1, 16'h5A5A});
        cyc();
        #1 check("final_idle", a_outs(), 56'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ram8_arbiter
`default_nettype wire

// File: doc/ram8_arbiter.md
RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 gives requester 0 fixed priority.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an access.
REQ-005 req0_we / req1_we  input  1  1 = write, 0 = read.
REQ-006 req0_addr / req1_addr  input  3  word address 0..7.
REQ-007 req0_wdata / req1_wdata  input  16  write data.
REQ-008 req0_ready / req1_ready  output  1  request accepted when valid & ready in the same cycle.
REQ-009 rsp0_valid / rsp1_valid  output  1  response available for requester n.
REQ-010 rsp0_rdata / rsp1_rdata  output  16  read data; 16'h0000 for write responses.
REQ-011 rsp0_ready / rsp1_ready  input  1  requester consumes response when valid & ready.
REQ-012 ram_in  output  16  data to the 8x16 RAM.
REQ-013 ram_address  output  3  RAM word select.
REQ-014 ram_load  output  1  RAM write enable; RAM writes at the CLK edge ending a cycle with ram_load=1.
REQ-015 ram_out  input  16  RAM read data, combinational in ram_address.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-017 IDLE: req_ready asserted combinationally for exactly one requester (the grantee) when any req_valid is high; both ready low when none valid.
REQ-018 Grant: single requester valid -> that requester; both valid, FIXED_PRIO=1 -> requester 0; both valid, FIXED_PRIO=0 -> requester not granted last (last_grant resets to 1, so requester 0 wins first tie).
REQ-019 On handshake, owner id, we, addr, wdata SHALL be registered and FSM -> ACCESS; last_grant updated to owner.
REQ-020 ACCESS (exactly one cycle): ram_address = captured addr; ram_in = captured wdata; ram_load = captured we; read: ram_out captured into response register at edge; write: response register = 0; FSM -> RESP.
REQ-021 Outside ACCESS: ram_load = 0, ram_address = 0, ram_in = 0.
REQ-022 RESP: rsp_valid of owner only = 1, rsp_rdata of owner = response register, other requester's rsp_valid = 0 and rdata = 0; both req_ready = 0.
REQ-023 RESP -> IDLE on owner rsp_ready = 1; rsp_valid/rdata held stable until then; non-owner rsp_ready ignored.
REQ-024 Latency: handshake cycle N, RAM access N+1, rsp_valid from N+2; max throughput one access per 3 cycles.
REQ-025 Requests not granted SHALL wait with no side effect; requester must hold valid/fields stable until ready.
REQ-026 A read following a write to same address returns the new value (write completes before next ACCESS).

Reset
REQ-027 reset SHALL force FSM=IDLE, last_grant=1, owner=0, captured fields and response register=0 in the same edge; all outputs 0 next cycle.
REQ-028 reset during ACCESS: ram_load forced 0 that cycle onward; the write SHALL NOT occur if reset is high at the edge; pending response discarded.

Structure
REQ-029 Shared package holds FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and widths DATA_W=16, ADDR_W=3.
REQ-030 Grant logic SHALL be a sub-module rr_arb2 (2 requests, last_grant, FIXED_PRIO -> one-hot grant); RAM8 instantiated outside this block.

Verification
REQ-031 Write: req0 we=1 addr=3 wdata=16'hBEEF -> ram_load=1, ram_address=3 in N+1; rsp0_valid N+2, rdata=0.
REQ-032 Read back: req1 read addr=3 -> rsp1_rdata=16'hBEEF, rsp0_valid stays 0.
REQ-033 Tie, FIXED_PRIO=0: both valid continuously, 4 accesses -> grants 0,1,0,1.
REQ-034 Tie, FIXED_PRIO=1: both valid for 2 accesses -> grants 0,0; req1 ready never high.
REQ-035 Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid held, rdata stable, both req_ready=0; IDLE after ready=1.
REQ-036 Reset in ACCESS of write addr=5 data=16'h1234 -> addr 5 unchanged on later read, all outputs 0 after reset.
